// File: rtl/ps2_line_editor.sv
// rtl/ps2_line_editor.sv - PS/2 keystroke line editor with committed-line handoff
// Edge-detected key events edit a live buffer; Enter snapshots it for a consumer.
module ps2_line_editor #(
   parameter int MAX_CHARS = 32,
   parameter int CHAR_W    = 8,
   localparam int CW       = $clog2(MAX_CHARS + 1)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        key_pressed,
   input  logic [CHAR_W-1:0]           ascii_char,
   input  logic                        line_ack,
   output logic [MAX_CHARS*CHAR_W-1:0] edit_content,
   output logic [CW-1:0]               edit_count,
   output logic [MAX_CHARS*CHAR_W-1:0] line_content,
   output logic [CW-1:0]               line_length,
   output logic                        line_valid,
   output logic                        overflow,
   output logic                        dropped
);

   localparam int BW = MAX_CHARS * CHAR_W;
   localparam logic [CHAR_W-1:0] C_BS    = CHAR_W'(8'h08);
   localparam logic [CHAR_W-1:0] C_ENTER = CHAR_W'(8'h0A);
   localparam logic [CHAR_W-1:0] C_ESC   = CHAR_W'(8'h1B);
   localparam logic [CHAR_W-1:0] C_SPACE = CHAR_W'(8'h20);
   localparam logic [CHAR_W-1:0] C_TILDE = CHAR_W'(8'h7E);

   typedef enum logic {S_EMPTY, S_PENDING} state_t;

   state_t          r_state, w_next_state;
   logic            r_prev_key;
   logic [BW-1:0]   r_edit, w_edit_nxt;
   logic [CW-1:0]   r_edit_count, w_count_nxt;
   logic [BW-1:0]   r_line;
   logic [CW-1:0]   r_line_len;
   logic            r_overflow, w_overflow_nxt;
   logic            r_dropped;
   logic            w_event, w_enter, w_commit, w_drop, w_printable;

   assign w_event     = key_pressed & ~r_prev_key;
   assign w_enter     = w_event && (ascii_char == C_ENTER);
   assign w_printable = (ascii_char >= C_SPACE) && (ascii_char <= C_TILDE);

   always_comb begin
      w_next_state = r_state;
      w_commit     = 1'b0;
      w_drop       = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_enter) begin
               w_commit     = 1'b1;
               w_next_state = S_PENDING;
            end
         end
         S_PENDING: begin
            // Ack and Enter together hand over the old line and commit the new one at once.
            if (w_enter && line_ack) begin
               w_commit = 1'b1;
            end else if (w_enter) begin
               w_drop = 1'b1;
            end else if (line_ack) begin
               w_next_state = S_EMPTY;
            end
         end
         default: w_next_state = S_EMPTY;
      endcase
   end

   always_comb begin
      w_edit_nxt     = r_edit;
      w_count_nxt    = r_edit_count;
      w_overflow_nxt = r_overflow;
      if (w_commit || (w_event && ascii_char == C_ESC)) begin
         w_edit_nxt     = '0;
         w_count_nxt    = '0;
         w_overflow_nxt = 1'b0;
      end else if (w_event && w_printable) begin
         if (r_edit_count < CW'(MAX_CHARS)) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
               if (CW'(i) == r_edit_count) begin
                  w_edit_nxt[BW-1-i*CHAR_W -: CHAR_W] = ascii_char;
               end
            end
            w_count_nxt = r_edit_count + CW'(1);
         end else begin
            w_overflow_nxt = 1'b1;
         end
      end else if (w_event && ascii_char == C_BS && r_edit_count != '0) begin
         for (int i = 0; i < MAX_CHARS; i++) begin
            if (CW'(i + 1) == r_edit_count) begin
               w_edit_nxt[BW-1-i*CHAR_W -: CHAR_W] = '0;
            end
         end
         w_count_nxt = r_edit_count - CW'(1);
      end
   end

   // Previous-key sample resets high so a strobe held across reset release is ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_EMPTY;
         r_prev_key   <= 1'b1;
         r_edit       <= '0;
         r_edit_count <= '0;
         r_line       <= '0;
         r_line_len   <= '0;
         r_overflow   <= 1'b0;
         r_dropped    <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_prev_key   <= key_pressed;
         r_edit       <= w_edit_nxt;
         r_edit_count <= w_count_nxt;
         r_overflow   <= w_overflow_nxt;
         if (w_commit) begin
            r_line     <= r_edit;
            r_line_len <= r_edit_count;
         end
         if (w_drop) begin
            r_dropped <= 1'b1;
         end
      end
   end

   assign edit_content = r_edit;
   assign edit_count   = r_edit_count;
   assign line_content = r_line;
   assign line_length  = r_line_len;
   assign line_valid   = (r_state == S_PENDING);
   assign overflow     = r_overflow;
   assign dropped      = r_dropped;

endmodule

// File: tb/tb_ps2_line_editor.sv
// tb/tb_ps2_line_editor.sv - scoreboard bench for ps2_line_editor
// Stimulus queues expected snapshots; monitors compare at negedge and on line_valid rise.
module tb_ps2_line_editor;

   localparam int MC = 32;
   localparam int W  = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          key_pressed;
   logic [7:0]    ascii_char;
   logic          line_ack;
   logic [255:0]  edit_content, line_content;
   logic [5:0]    edit_count, line_length;
   logic          line_valid, overflow, dropped;

   ps2_line_editor #(.MAX_CHARS(MC), .CHAR_W(W)) dut (
      .clock(clock), .reset(reset), .key_pressed(key_pressed), .ascii_char(ascii_char),
      .line_ack(line_ack), .edit_content(edit_content), .edit_count(edit_count),
      .line_content(line_content), .line_length(line_length), .line_valid(line_valid),
      .overflow(overflow), .dropped(dropped)
   );

   always #5 clock = ~clock;

   typedef struct {
      string        name;
      logic [5:0]   ecnt;
      logic [255:0] econt;
      logic [5:0]   lcnt;
      logic [255:0] lcont;
      logic         lv;
      logic         ovf;
      logic         drp;
   } exp_t;

   typedef struct {
      logic [5:0]   len;
      logic [255:0] cont;
   } line_t;

   exp_t  q_exp[$];
   line_t q_line[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   logic  r_prev_lv = 1'b0;

   task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   always @(negedge clock) begin
      exp_t  e;
      line_t l;
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         cmp({e.name, ".edit_count"},   256'(edit_count),   256'(e.ecnt));
         cmp({e.name, ".edit_content"}, edit_content,       e.econt);
         cmp({e.name, ".line_length"},  256'(line_length),  256'(e.lcnt));
         cmp({e.name, ".line_content"}, line_content,       e.lcont);
         cmp({e.name, ".line_valid"},   256'(line_valid),   256'(e.lv));
         cmp({e.name, ".overflow"},     256'(overflow),     256'(e.ovf));
         cmp({e.name, ".dropped"},      256'(dropped),      256'(e.drp));
      end
      if (line_valid === 1'b1 && r_prev_lv === 1'b0) begin
         if (q_line.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL commit: unexpected line_valid rise, length %0d", line_length);
         end else begin
            l = q_line.pop_front();
            cmp("commit.length",  256'(line_length), 256'(l.len));
            cmp("commit.content", line_content,      l.cont);
         end
      end
      r_prev_lv = line_valid;
   end

   function automatic logic [255:0] pack(input string s);
      logic [255:0] r = '0;
      for (int i = 0; i < s.len(); i++) r[255-i*8 -: 8] = s[i];
      return r;
   endfunction

   function automatic logic [255:0] fill(input logic [7:0] ch, input int n);
      logic [255:0] r = '0;
      for (int i = 0; i < n; i++) r[255-i*8 -: 8] = ch;
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [7:0] ch, input int hold);
      key_pressed = 1'b1;
      ascii_char  = ch;
      repeat (hold) tick();
      key_pressed = 1'b0;
      tick();
   endtask

   task automatic type_str(input string s);
      for (int i = 0; i < s.len(); i++) press(s[i], 1);
   endtask

   task automatic expect_state(input string nm, input logic [5:0] ecnt, input logic [255:0] econt,
                               input logic [5:0] lcnt, input logic [255:0] lcont,
                               input logic lv, input logic ovf, input logic drp);
      exp_t e;
      e.name = nm; e.ecnt = ecnt; e.econt = econt; e.lcnt = lcnt; e.lcont = lcont;
      e.lv = lv; e.ovf = ovf; e.drp = drp;
      q_exp.push_back(e);
   endtask

   task automatic expect_commit(input logic [5:0] len, input logic [255:0] cont);
      line_t l;
      l.len = len; l.cont = cont;
      q_line.push_back(l);
   endtask

   task automatic ack_pulse();
      line_ack = 1'b1;
      tick();
      line_ack = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; key_pressed = 1'b0; ascii_char = 8'h00; line_ack = 1'b0;
      tick();
      expect_state("reset", 0, '0, 0, '0, 0, 0, 0);
      tick();
      reset = 1'b0;
      tick();

      type_str("HI");
      expect_state("hi_typed", 2, pack("HI"), 0, '0, 0, 0, 0);
      expect_commit(2, pack("HI"));
      press(8'h0A, 1);
      expect_state("hi_commit", 0, '0, 2, pack("HI"), 1, 0, 0);
      ack_pulse();
      expect_state("hi_acked", 0, '0, 2, pack("HI"), 0, 0, 0);

      ack_pulse();
      expect_state("ack_in_empty", 0, '0, 2, pack("HI"), 0, 0, 0);

      type_str("AB");
      press(8'h08, 1); press(8'h08, 1); press(8'h08, 1);
      expect_state("bs_underflow", 0, '0, 2, pack("HI"), 0, 0, 0);

      press(8'h01, 1);
      press(8'h7F, 1);
      expect_state("ignored_codes", 0, '0, 2, pack("HI"), 0, 0, 0);

      for (int i = 0; i < 33; i++) press(8'h41, 1);
      expect_state("overflow_full", 32, fill(8'h41, 32), 2, pack("HI"), 0, 1, 0);
      press(8'h08, 1);
      expect_state("bs_from_full", 31, fill(8'h41, 31), 2, pack("HI"), 0, 1, 0);
      press(8'h1B, 1);
      expect_state("escape", 0, '0, 2, pack("HI"), 0, 0, 0);

      press(8'h41, 10);
      expect_state("long_strobe", 1, pack("A"), 2, pack("HI"), 0, 0, 0);
      press(8'h1B, 1);

      expect_commit(1, pack("X"));
      type_str("X");
      press(8'h0A, 1);
      type_str("Y");
      press(8'h0A, 1);
      expect_state("enter_dropped", 1, pack("Y"), 1, pack("X"), 1, 0, 1);
      key_pressed = 1'b1; ascii_char = 8'h0A; line_ack = 1'b1;
      tick();
      key_pressed = 1'b0; line_ack = 1'b0;
      tick();
      expect_state("enter_with_ack", 0, '0, 1, pack("Y"), 1, 0, 1);
      ack_pulse();
      expect_state("y_acked", 0, '0, 1, pack("Y"), 0, 0, 1);

      expect_commit(0, '0);
      press(8'h0A, 1);
      expect_state("zero_len_commit", 0, '0, 0, '0, 1, 0, 1);
      ack_pulse();

      expect_commit(1, pack("Q"));
      type_str("Q");
      press(8'h0A, 1);
      key_pressed = 1'b1; ascii_char = 8'h5A; reset = 1'b1;
      #1;
      expect_state("async_reset", 0, '0, 0, '0, 0, 0, 0);
      tick(); tick();
      reset = 1'b0;
      repeat (3) tick();
      expect_state("held_through_reset", 0, '0, 0, '0, 0, 0, 0);
      key_pressed = 1'b0;
      tick();
      press(8'h4B, 1);
      expect_state("after_reset_key", 1, pack("K"), 0, '0, 0, 0, 0);

      tick(); tick();
      n_checks++;
      if (q_line.size() != 0) begin
         n_fail++;
         $display("FAIL commit_drain: %0d expected commits never seen, required 0", q_line.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
